// File: rtl/lms_pkg.sv
//------------------------------------------------------------------------------
// Package  : lms_pkg
// Purpose  : Shared definitions for the LMS error-generation stage:
//            FSM state encoding, accumulator width derivation and a
//            signed saturation helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lms_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CALC  = 3'd3,
    ST_OUT   = 3'd4
  } lms_state_e;

  // Accumulator width: one product width plus growth for summing TAPS terms.
  function automatic int acc_width(input int x_w, input int w_w, input int taps);
    return x_w + w_w + $clog2(taps);
  endfunction

  // Clamp a signed value to the two's-complement range of 'width' bits.
  // Intended for constant 'width' so only the comparators remain in hardware.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int                 width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lms_tap_delay.sv
//------------------------------------------------------------------------------
// Module   : lms_tap_delay
// Purpose  : x[n] delay line for the LMS filter. TAPS x X_W shift register
//            with shift enable and a random-access read port by tap index.
// Ports    : clk, rst_n (async, active low)
//            shift_i  - push x_i into position 0, older samples move up
//            x_i      - new sample
//            idx_i    - tap index to read
//            x_o      - x[n-idx_i]
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lms_tap_delay #(
  parameter int TAPS = 8,
  parameter int X_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      shift_i,
  input  logic signed [X_W-1:0]     x_i,
  input  logic [$clog2(TAPS)-1:0]   idx_i,
  output logic signed [X_W-1:0]     x_o
);

  logic signed [X_W-1:0] dl_q [TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        dl_q[k] <= '0;
      end
    end else if (shift_i) begin
      dl_q[0] <= x_i;
      for (int k = 1; k < TAPS; k++) begin
        dl_q[k] <= dl_q[k-1];
      end
    end
  end

  assign x_o = dl_q[idx_i];

endmodule

`default_nettype wire

// File: rtl/lms_err_gen.sv
//------------------------------------------------------------------------------
// Module   : lms_err_gen
// Purpose  : LMS error-generation stage. Holds the x[n] delay line, serves the
//            tap cells one at a time (tap_en/tap_idx/tap_x out, tap_y back),
//            accumulates their products, then forms
//              y   = acc >>> FRAC
//              err = (d - y) >>> MU_SHIFT
//            and strobes err/y_out with err_vld.
// Ports    : clk, rst_n (async, active low)
//            sample_vld/sample_rdy, x_in, d_in  - sample input handshake
//            tap_en, tap_idx, tap_x             - tap request
//            tap_y, tap_y_vld                   - tap product return
//            err, y_out, err_vld                - results
// Config   : LMS_ERR_SAT_EN - when defined, y_out and err saturate to their
//            signed ranges; otherwise they wrap (low-order bits kept).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lms_err_gen
  import lms_pkg::*;
#(
  parameter int TAPS     = 8,
  parameter int X_W      = 16,
  parameter int W_W      = 16,
  parameter int E_W      = 16,
  parameter int FRAC     = 15,
  parameter int MU_SHIFT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sample_vld,
  output logic                        sample_rdy,
  input  logic signed [X_W-1:0]       x_in,
  input  logic signed [X_W-1:0]       d_in,
  output logic                        tap_en,
  output logic [$clog2(TAPS)-1:0]     tap_idx,
  output logic signed [X_W-1:0]       tap_x,
  input  logic signed [X_W+W_W-1:0]   tap_y,
  input  logic                        tap_y_vld,
  output logic signed [E_W-1:0]       err,
  output logic                        err_vld,
  output logic signed [X_W-1:0]       y_out
);

  localparam int IDX_W = $clog2(TAPS);
  localparam int TY_W  = X_W + W_W;
  localparam int ACC_W = acc_width(X_W, W_W, TAPS);
  localparam int YF_W  = ACC_W - FRAC;
  // d - y is kept at full precision so an overflowing y still produces the
  // correctly signed (and, with saturation, correctly clamped) error.
  localparam int EF_W  = ((YF_W > X_W) ? YF_W : X_W) + 1;

  lms_state_e               state_q;
  logic [IDX_W-1:0]         idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [X_W-1:0]    d_q;
  logic signed [YF_W-1:0]   yf_q;
  logic signed [EF_W-1:0]   es_q;
  logic                     tap_en_q;
  logic                     rdy_q;
  logic                     err_vld_q;
  logic signed [E_W-1:0]    err_q;
  logic signed [X_W-1:0]    y_q;

  logic                     accept_d;
  logic signed [YF_W-1:0]   yf_d;
  logic signed [EF_W-1:0]   e_d;
  logic signed [EF_W-1:0]   es_d;
  logic signed [X_W-1:0]    y_res_d;
  logic signed [E_W-1:0]    err_res_d;

  assign accept_d = (state_q == ST_IDLE) && sample_vld && rdy_q;

  lms_tap_delay #(
    .TAPS (TAPS),
    .X_W  (X_W)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .shift_i (accept_d),
    .x_i     (x_in),
    .idx_i   (idx_q),
    .x_o     (tap_x)
  );

  // Arithmetic shift by FRAC is a plain slice of the accumulator's upper bits.
  assign yf_d = acc_q[ACC_W-1:FRAC];
  assign e_d  = EF_W'(d_q) - EF_W'(yf_d);
  assign es_d = e_d >>> MU_SHIFT;

`ifdef LMS_ERR_SAT_EN
  assign y_res_d   = X_W'(sat_signed(64'(yf_q), X_W));
  assign err_res_d = E_W'(sat_signed(64'(es_q), E_W));
`else
  assign y_res_d   = X_W'(yf_q);
  assign err_res_d = E_W'(es_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      d_q       <= '0;
      yf_q      <= '0;
      es_q      <= '0;
      tap_en_q  <= 1'b0;
      rdy_q     <= 1'b0;
      err_vld_q <= 1'b0;
      err_q     <= '0;
      y_q       <= '0;
    end else begin
      tap_en_q  <= 1'b0;
      err_vld_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rdy_q <= 1'b1;
          if (accept_d) begin
            rdy_q    <= 1'b0;
            d_q      <= d_in;
            acc_q    <= '0;
            idx_q    <= '0;
            tap_en_q <= 1'b1;   // pulse is visible during ISSUE
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tap_y_vld) begin
            acc_q <= acc_q + {{(ACC_W-TY_W){tap_y[TY_W-1]}}, tap_y};
            if (idx_q == IDX_W'(TAPS - 1)) begin
              state_q <= ST_CALC;
            end else begin
              idx_q    <= idx_q + 1'b1;
              tap_en_q <= 1'b1;
              state_q  <= ST_ISSUE;
            end
          end
        end
        ST_CALC: begin
          yf_q    <= yf_d;
          es_q    <= es_d;
          state_q <= ST_OUT;
        end
        ST_OUT: begin
          y_q       <= y_res_d;
          err_q     <= err_res_d;
          err_vld_q <= 1'b1;
          rdy_q     <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          rdy_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sample_rdy = rdy_q;
  assign tap_en     = tap_en_q;
  assign tap_idx    = idx_q;
  assign err        = err_q;
  assign err_vld    = err_vld_q;
  assign y_out      = y_q;

endmodule

`default_nettype wire

// File: tb/tb_lms_err_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_lms_err_gen
// Purpose  : Self-checking bench for lms_err_gen. A tap responder answers
//            tap_en requests with chosen products after a chosen delay; the
//            expected y/err per sample is computed with plain integer
//            arithmetic and queued, and a monitor pops it on every err_vld.
//            Follows LMS_ERR_SAT_EN for the expected overflow behaviour.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lms_err_gen;

  localparam int TAPS     = 8;
  localparam int X_W      = 16;
  localparam int W_W      = 16;
  localparam int E_W      = 16;
  localparam int FRAC     = 15;
  localparam int MU_SHIFT = 4;
  localparam int IW       = $clog2(TAPS);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      sample_vld;
  logic                      sample_rdy;
  logic signed [X_W-1:0]     x_in;
  logic signed [X_W-1:0]     d_in;
  logic                      tap_en;
  logic [IW-1:0]             tap_idx;
  logic signed [X_W-1:0]     tap_x;
  logic signed [X_W+W_W-1:0] tap_y;
  logic                      tap_y_vld;
  logic signed [E_W-1:0]     err;
  logic                      err_vld;
  logic signed [X_W-1:0]     y_out;

  always #5 clk = ~clk;

  lms_err_gen #(
    .TAPS(TAPS), .X_W(X_W), .W_W(W_W), .E_W(E_W), .FRAC(FRAC), .MU_SHIFT(MU_SHIFT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_vld (sample_vld),
    .sample_rdy (sample_rdy),
    .x_in       (x_in),
    .d_in       (d_in),
    .tap_en     (tap_en),
    .tap_idx    (tap_idx),
    .tap_x      (tap_x),
    .tap_y      (tap_y),
    .tap_y_vld  (tap_y_vld),
    .err        (err),
    .err_vld    (err_vld),
    .y_out      (y_out)
  );

  typedef struct {
    logic signed [X_W-1:0] y;
    logic signed [E_W-1:0] e;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  logic signed [X_W-1:0]     mdl    [TAPS];  // reference delay line, newest first
  logic signed [X_W-1:0]     seen_x [TAPS];  // last tap_x observed per index
  logic signed [X_W+W_W-1:0] resp   [TAPS];  // product each tap returns
  int   cur_dly = 1;
  bit   spur    = 1'b0;
  int   exp_idx = 0;
  int   n_vld   = 0;
  int   n_done  = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reduce a mathematically exact result to a 16-bit output.
  function automatic logic signed [15:0] fit16(input longint v);
`ifdef LMS_ERR_SAT_EN
    if (v > 32767)  return 16'sh7FFF;
    if (v < -32768) return 16'sh8000;
`endif
    return v[15:0];
  endfunction

  // Tap responder: answers each tap_en after cur_dly cycles.
  initial begin : responder
    int pend;
    logic signed [X_W+W_W-1:0] pval;
    pend = 0;
    pval = '0;
    tap_y_vld = 1'b0;
    tap_y = '0;
    forever begin
      @(posedge clk); #1;
      tap_y_vld = 1'b0;
      if (!rst_n) begin
        pend = 0;
        exp_idx = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            tap_y_vld = 1'b1;
            tap_y = pval;
          end
        end else if (spur) begin
          spur = 1'b0;
          tap_y_vld = 1'b1;
          tap_y = 32'sh1234_5678;
        end
        if (tap_en) begin
          chk("tap_en_while_busy", pend, 0);
          chk("tap_idx", tap_idx, exp_idx);
          chk("tap_x", tap_x, mdl[tap_idx]);
          seen_x[tap_idx] = tap_x;
          pval = resp[tap_idx];
          pend = cur_dly;
          exp_idx = (exp_idx + 1) % TAPS;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    exp_t ex;
    forever begin
      @(posedge clk); #1;
      if (rst_n && err_vld) begin
        n_vld++;
        if (exp_q.size() == 0) begin
          chk("unexpected_err_vld", 1, 0);
        end else begin
          ex = exp_q.pop_front();
          chk("y_out", y_out, ex.y);
          chk("err", err, ex.e);
        end
      end
    end
  end

  // Offer one sample; on acceptance, update the model and queue the expectation.
  task automatic accept(input logic signed [X_W-1:0] x, input logic signed [X_W-1:0] d,
                        input int dly);
    longint acc, y, e, es;
    exp_t ex;
    int n;
    n = 0;
    while (!sample_rdy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sample_rdy_before_send", sample_rdy, 1);
    if (sample_rdy) begin
      cur_dly = dly;
      sample_vld = 1'b1;
      x_in = x;
      d_in = d;
      for (int k = TAPS - 1; k > 0; k--) mdl[k] = mdl[k-1];
      mdl[0] = x;
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += longint'(resp[k]);
      y  = acc >>> FRAC;
      e  = longint'(d) - y;
      es = e >>> MU_SHIFT;
      ex.y = fit16(y);
      ex.e = fit16(es);
      exp_q.push_back(ex);
      @(posedge clk); #1;
      sample_vld = 1'b0;
    end
  endtask

  // Wait for err_vld; the accept cycle counts as cycle 1.
  task automatic wait_done(input bit chk_lat, input bit mid_vld);
    int lat;
    lat = 1;
    while (!err_vld && lat < 600) begin
      if (mid_vld && lat >= 3 && lat <= 6) begin
        sample_vld = 1'b1;
        x_in = 16'($urandom);
        d_in = 16'($urandom);
        if (lat == 4) chk("rdy_low_while_busy", sample_rdy, 0);
      end else begin
        sample_vld = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    sample_vld = 1'b0;
    chk("err_vld_seen", err_vld, 1);
    if (err_vld) begin
      n_done++;
      if (chk_lat) chk("latency", lat, 2 * TAPS + 3);
      @(posedge clk); #1;
      chk("err_vld_single_cycle", err_vld, 0);
    end
  endtask

  task automatic set_resp(input logic signed [X_W+W_W-1:0] v);
    for (int k = 0; k < TAPS; k++) resp[k] = v;
  endtask

  task automatic rand_resp();
    for (int k = 0; k < TAPS; k++) resp[k] = 32'($urandom);
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0;
    sample_vld = 1'b0;
    x_in = '0;
    d_in = '0;
    for (int k = 0; k < TAPS; k++) begin
      mdl[k] = '0;
      seen_x[k] = '0;
      resp[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample_rdy", sample_rdy, 0);
    chk("rst_err_vld", err_vld, 0);
    chk("rst_tap_en", tap_en, 0);
    chk("rst_err", err, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_tap_idx", tap_idx, 0);
    chk("rst_tap_x", tap_x, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse: all taps return zero.
    set_resp('0);
    accept(16'sh4000, 16'sh0000, 1);
    wait_done(1'b1, 1'b0);

    // Accumulate: 8 x 0x8000 -> y = 8, err = (256 - 8) >>> 4 = 15.
    set_resp(32'sh0000_8000);
    accept(16'sh0011, 16'sh0100, 1);
    wait_done(1'b1, 1'b0);

    // Saturation / wrap.
    set_resp(32'sh7FFF_FFFF);
    accept(16'sh0022, -16'sd32768, 1);
    wait_done(1'b1, 1'b0);

    // Delay line: x = 1..9.
    set_resp('0);
    for (int i = 1; i <= 9; i++) begin
      accept(16'(i), 16'sh0000, 1);
      wait_done(1'b1, 1'b0);
    end
    for (int k = 0; k < TAPS; k++) chk("delay_line_after_9", seen_x[k], 9 - k);

    // Handshake: slow taps, spurious tap_y_vld in IDLE, sample_vld mid-op.
    for (int i = 0; i < 2; i++) begin
      rand_resp();
      spur = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      accept(16'($urandom), 16'($urandom), 5);
      wait_done(1'b0, 1'b1);
    end

    // Reset while waiting on tap 3.
    rand_resp();
    accept(16'($urandom), 16'($urandom), 20);
    n = 0;
    while (!(tap_en && tap_idx == 3) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_tap3", (tap_en && tap_idx == 3), 1);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_err_vld", err_vld, 0);
    chk("midrst_tap_en", tap_en, 0);
    chk("midrst_tap_idx", tap_idx, 0);
    chk("midrst_tap_x", tap_x, 0);
    chk("midrst_sample_rdy", sample_rdy, 0);
    chk("midrst_err", err, 0);
    chk("midrst_y_out", y_out, 0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    for (int k = 0; k < TAPS; k++) mdl[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rdy_after_reset", sample_rdy, 1);
    rand_resp();
    accept(16'sh1234, 16'($urandom), 1);
    wait_done(1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 20; i++) begin
      int dly;
      dly = int'($urandom_range(1, 3));
      rand_resp();
      accept(16'($urandom), 16'($urandom), dly);
      wait_done(dly == 1, 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("err_vld_count", n_vld, n_done);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
